// File: rtl/async_bridge_pkg.sv
// -----------------------------------------------------------------------------
// async_bridge_pkg
// Shared defaults for the async_rx_bridge block.
//   DEF_DATA_WIDTH : default bundled-data payload width
//   DEF_DEPTH      : default FIFO depth (power of two, >= 2)
//   SYNC_STAGES    : number of synchronizer flops on the incoming request
// Configuration macro: ASYNC_RX_SYNC3_EN
//   defined   -> 3-flop request synchronizer (write lands one edge later)
//   undefined -> 2-flop request synchronizer
// -----------------------------------------------------------------------------
package async_bridge_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_DEPTH      = 4;

`ifdef ASYNC_RX_SYNC3_EN
   localparam int SYNC_STAGES = 3;
`else
   localparam int SYNC_STAGES = 2;
`endif

endpackage : async_bridge_pkg

// File: rtl/async_req_sync.sv
// -----------------------------------------------------------------------------
// async_req_sync
// Multi-flop level synchronizer for the two-phase request wire.
// Parameters:
//   STAGES : number of flops in the chain (>= 2)
// Ports:
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, clears the whole chain to 0
//   d_i    : asynchronous input level
//   q_o    : synchronized level, STAGES edges behind d_i
// -----------------------------------------------------------------------------
module async_req_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   // Shift the raw level in at bit 0; the last bit is the only one used.
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d_i};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule : async_req_sync

// File: rtl/async_rx_bridge.sv
// -----------------------------------------------------------------------------
// async_rx_bridge
// Receives bundled-data tokens from an asynchronous two-phase (toggle)
// handshake and queues them in a first-word-fall-through FIFO for a
// synchronous valid/ready consumer.
// Parameters:
//   DATA_WIDTH : payload width
//   DEPTH      : FIFO entries, power of two, >= 2
// Ports:
//   clk_i   : clock, all state on rising edge
//   rst_ni  : asynchronous active-low reset
//   req_i   : two-phase request, every transition is one token
//   data_i  : bundled data, stable while the token is outstanding (not synchronized)
//   ack_o   : two-phase acknowledge, toggles once per accepted token (registered)
//   valid_o : FIFO head holds a token
//   data_o  : FIFO head data (first-word-fall-through)
//   ready_i : consumer takes the head when valid_o && ready_i
//   count_o : FIFO occupancy
// Handshakes:
//   Upstream: a token is outstanding while synchronized req differs from ack_o.
//   It is written and acknowledged on the same edge whenever the registered
//   occupancy is below DEPTH; otherwise it waits, and is never dropped.
//   Downstream: the head is popped on every edge where valid_o && ready_i.
// Configuration macro: ASYNC_RX_SYNC3_EN selects a 3-flop synchronizer
// (via async_bridge_pkg::SYNC_STAGES); default is 2 flops.
// -----------------------------------------------------------------------------
module async_rx_bridge
   import async_bridge_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         req_i,
   input  logic [DATA_WIDTH-1:0]        data_i,
   output logic                         ack_o,
   output logic                         valid_o,
   output logic [DATA_WIDTH-1:0]        data_o,
   input  logic                         ready_i,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic                  req_sync;
   logic                  pending;
   logic                  push;
   logic                  pop;
   logic                  ack_q, ack_d;
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   async_req_sync #(
      .STAGES (SYNC_STAGES)
   ) u_req_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (req_i),
      .q_o    (req_sync)
   );

   always_comb begin
      pending  = req_sync ^ ack_q;
      // Full is judged on the registered count only: a pop on the same edge
      // does not open a slot for the waiting token until the next edge.
      push     = pending && (count_q != FULL_CNT);
      pop      = (count_q != '0) && ready_i;

      ack_d    = ack_q ^ push;
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

      count_d  = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ack_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         ack_q    <= ack_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; its contents are only visible while valid_o=1.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   assign ack_o   = ack_q;
   assign valid_o = (count_q != '0);
   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule : async_rx_bridge

// File: tb/tb_async_rx_bridge.sv
// -----------------------------------------------------------------------------
// tb_async_rx_bridge
// Directed scoreboard bench for async_rx_bridge. Tokens are pushed into
// exp_q when sent; a negedge monitor pops and compares on every consumer
// transfer. Timing and occupancy are checked directly by the main sequence.
// -----------------------------------------------------------------------------
module tb_async_rx_bridge;
   import async_bridge_pkg::*;

   localparam int DW    = DEF_DATA_WIDTH;
   localparam int DEPTH = DEF_DEPTH;
   localparam int CW    = $clog2(DEPTH+1);
   localparam int LAT   = SYNC_STAGES;

   // ---------------- clock / reset ----------------
   logic          clk = 1'b0;
   logic          rst_ni;
   logic          req_i;
   logic [DW-1:0] data_i;
   logic          ack_o;
   logic          valid_o;
   logic [DW-1:0] data_o;
   logic          ready_i;
   logic [CW-1:0] count_o;

   always #5 clk = ~clk;

   async_rx_bridge #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH)
   ) dut (
      .clk_i   (clk),
      .rst_ni  (rst_ni),
      .req_i   (req_i),
      .data_i  (data_i),
      .ack_o   (ack_o),
      .valid_o (valid_o),
      .data_o  (data_o),
      .ready_i (ready_i),
      .count_o (count_o)
   );

   // ---------------- scoreboard state ----------------
   int            checks   = 0;
   int            failures = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] mon_exp;
   logic          wrap_mon = 1'b0;
   logic          ack_prev;
   logic          ack_exp;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Inputs change 2 time units after each rising edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [DW-1:0] d);
      data_i = d;
      req_i  = ~req_i;
      exp_q.push_back(d);
   endtask

   task automatic wait_ack(input string name);
      for (int i = 0; i < 20 && ack_o !== req_i; i++) tick();
      chk(name, 64'(ack_o), 64'(req_i));
   endtask

   task automatic wait_empty(input string name);
      for (int i = 0; i < 60 && count_o != '0; i++) tick();
      chk(name, 64'(count_o), 64'd0);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst_ni && valid_o && ready_i) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pop: got %0h expected no data", data_o);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("data_o", 64'(data_o), 64'(mon_exp));
         end
      end
      if (rst_ni && wrap_mon) begin
         chk("wrap_count_le1", 64'(count_o <= 1), 64'd1);
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog expired");
   end

   // ---------------- main sequence ----------------
   initial begin
      rst_ni  = 1'b0;
      req_i   = 1'b0;
      ready_i = 1'b0;
      data_i  = '0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_ack", 64'(ack_o), 64'd0);
      chk("rst_valid", 64'(valid_o), 64'd0);
      chk("rst_count", 64'(count_o), 64'd0);
      rst_ni = 1'b1;
      tick();

      // Single token: ack after LAT edges, visible after write, popped next edge.
      ready_i = 1'b1;
      send(32'hA5A5_0001);
      for (int i = 0; i < LAT; i++) begin
         tick();
         chk("t1_ack_early", 64'(ack_o), 64'd0);
         chk("t1_valid_early", 64'(valid_o), 64'd0);
      end
      tick();
      chk("t1_ack", 64'(ack_o), 64'd1);
      chk("t1_valid", 64'(valid_o), 64'd1);
      chk("t1_count", 64'(count_o), 64'd1);
      tick();
      chk("t1_count_after_pop", 64'(count_o), 64'd0);
      chk("t1_valid_after_pop", 64'(valid_o), 64'd0);

      // Fill to DEPTH with the consumer stalled; fifth token must wait.
      ready_i = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         send(DW'(k));
         wait_ack("t2_ack");
      end
      tick();
      chk("t2_count_full", 64'(count_o), 64'd4);
      ack_prev = ack_o;
      send(DW'(5));
      repeat (6) tick();
      chk("t2_fifth_blocked", 64'(ack_o), 64'(ack_prev));
      chk("t2_count_held", 64'(count_o), 64'd4);
      chk("t2_valid", 64'(valid_o), 64'd1);

      // Full with simultaneous pop: no push that edge, push on the next one.
      ready_i = 1'b1;
      tick();
      ready_i = 1'b0;
      chk("t3_no_ack_on_pop", 64'(ack_o), 64'(ack_prev));
      chk("t3_count_after_pop", 64'(count_o), 64'd3);
      tick();
      ack_exp = ~ack_prev;
      chk("t3_ack_next", 64'(ack_o), 64'(ack_exp));
      chk("t3_count_refill", 64'(count_o), 64'd4);
      ready_i = 1'b1;
      wait_empty("t3_drain");

      // Wrap: ten tokens through a streaming consumer.
      wrap_mon = 1'b1;
      for (int k = 0; k < 10; k++) begin
         send(32'hC0DE_0000 + DW'(k));
         wait_ack("t4_ack");
      end
      wait_empty("t4_drain");
      wrap_mon = 1'b0;

      // Reset mid-operation with a raised request outstanding.
      ready_i = 1'b0;
      send(32'h0000_00B1);
      wait_ack("t5_ack_b1");
      send(32'h0000_00B2);
      wait_ack("t5_ack_b2");
      tick();
      chk("t5_count_two", 64'(count_o), 64'd2);
      send(32'h0000_00B3);
      chk("t5_req_high", 64'(req_i), 64'd1);
      #1;
      rst_ni = 1'b0;
      #1;
      chk("t5_rst_ack", 64'(ack_o), 64'd0);
      chk("t5_rst_count", 64'(count_o), 64'd0);
      chk("t5_rst_valid", 64'(valid_o), 64'd0);
      exp_q.delete();
      repeat (2) tick();
      rst_ni = 1'b1;
      exp_q.push_back(32'h0000_00B3);
      for (int i = 0; i < LAT; i++) begin
         tick();
         chk("t5_ack_early", 64'(ack_o), 64'd0);
      end
      tick();
      chk("t5_ack_after_rst", 64'(ack_o), 64'd1);
      chk("t5_count_after_rst", 64'(count_o), 64'd1);
      repeat (3) tick();
      chk("t5_single_token", 64'(count_o), 64'd1);
      ready_i = 1'b1;
      wait_empty("t5_drain");

      repeat (5) tick();
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_async_rx_bridge
